// File: rtl/exec_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// exec_ctrl_fsm
//
// Multi-cycle execute controller. Accepts one instruction word per valid/ready
// handshake, then sequences register-file read, ALU execute and write-back.
// Owns the program counter and a zero flag that is latched from the ALU on
// ALU ops. Adds JMP, JZ (on the latched zero flag), HALT and illegal-opcode
// handling.
//
// Instruction fields, MSB to LSB: op[OP_W], dst[RA_W], srcA[RA_W], srcB[RA_W]
// Opcodes: 0x0-0x3 ALU (alu_fs = op[1:0]), 0x4 MOV, 0x5 JMP, 0x6 JZ,
//          0x7 HALT, anything else illegal (executed as a NOP).
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   instr_valid  in   instruction word available
//   instr        in   instruction word (INSTR_W)
//   instr_ready  out  controller can accept an instruction (IDLE)
//   pc           out  program counter, address of the next fetch
//   rd_en        out  register-file read strobe (READ)
//   rd_sel_a/b   out  read selects (srcA / srcB), 0 outside READ/EXEC/WRITE
//   wr_en        out  register-file write strobe, one-cycle pulse (WRITE)
//   wr_sel       out  write select (dst), 0 outside READ/EXEC/WRITE
//   mov_sel      out  1 = write-back from read port A, 0 = ALU result
//   alu_fs       out  ALU function, valid in EXEC/WRITE of ALU ops
//   alu_zero     in   ALU result-is-zero (combinational from the ALU)
//   halted       out  controller is in HALT
//   illegal      out  one-cycle pulse on an undefined opcode
// ---------------------------------------------------------------------------
module exec_ctrl_fsm #(
    parameter int OP_W = 4,
    parameter int RA_W = 5,
    parameter int PC_W = 5,
    localparam int INSTR_W = OP_W + 3 * RA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [PC_W-1:0]    pc,
    output logic               rd_en,
    output logic [RA_W-1:0]    rd_sel_a,
    output logic [RA_W-1:0]    rd_sel_b,
    output logic               wr_en,
    output logic [RA_W-1:0]    wr_sel,
    output logic               mov_sel,
    output logic [1:0]         alu_fs,
    input  logic               alu_zero,
    output logic               halted,
    output logic               illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_z;
    logic [INSTR_W-1:0] r_instr;

    // Field extraction from the captured instruction word.
    logic [OP_W-1:0] w_op;
    logic [RA_W-1:0] w_dst;
    logic [RA_W-1:0] w_src_a;
    logic [RA_W-1:0] w_src_b;

    assign w_op    = r_instr[INSTR_W-1 -: OP_W];
    assign w_dst   = r_instr[3*RA_W-1 -: RA_W];
    assign w_src_a = r_instr[2*RA_W-1 -: RA_W];
    assign w_src_b = r_instr[RA_W-1:0];

    logic w_is_alu;
    logic w_is_mov;
    logic w_is_jmp;
    logic w_is_jz;
    logic w_is_halt;
    logic w_is_illegal;

    assign w_is_alu     = (w_op < OP_W'(4));
    assign w_is_mov     = (w_op == OP_W'(4));
    assign w_is_jmp     = (w_op == OP_W'(5));
    assign w_is_jz      = (w_op == OP_W'(6));
    assign w_is_halt    = (w_op == OP_W'(7));
    assign w_is_illegal = (w_op > OP_W'(7));

    // Size cast truncates srcB when PC_W <= RA_W and zero-extends otherwise.
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;

    assign w_target = PC_W'(w_src_b);
    assign w_pc_inc = r_pc + PC_W'(1);   // wraps modulo 2**PC_W

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the instruction register is a single register, not a memory
            // array, so clearing it on reset is cheap and keeps decode outputs
            // deterministic after reset.
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_z     <= 1'b0;
            r_instr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_is_alu || w_is_mov) begin
                        r_state <= S_READ;
                    end else if (w_is_jmp) begin
                        r_pc    <= w_target;
                        r_state <= S_IDLE;
                    end else if (w_is_jz) begin
                        r_pc    <= r_z ? w_target : w_pc_inc;
                        r_state <= S_IDLE;
                    end else if (w_is_halt) begin
                        r_state <= S_HALT;
                    end else begin
                        // Illegal opcode: behaves as a NOP and advances pc.
                        r_pc    <= w_pc_inc;
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_state <= w_is_alu ? S_EXEC : S_WRITE;
                end
                S_EXEC: begin
                    r_z     <= alu_zero;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_IDLE;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded purely from state, so an asynchronous reset clears
    // every strobe immediately, without waiting for a clock edge.
    logic w_sel_active;

    assign w_sel_active = (r_state == S_READ) || (r_state == S_EXEC) ||
                          (r_state == S_WRITE);

    assign instr_ready = (r_state == S_IDLE);
    assign pc          = r_pc;
    assign rd_en       = (r_state == S_READ);
    assign rd_sel_a    = w_sel_active ? w_src_a : '0;
    assign rd_sel_b    = w_sel_active ? w_src_b : '0;
    assign wr_en       = (r_state == S_WRITE);
    assign wr_sel      = w_sel_active ? w_dst : '0;
    assign mov_sel     = (r_state == S_WRITE) && w_is_mov;
    assign alu_fs      = (((r_state == S_EXEC) || (r_state == S_WRITE)) && w_is_alu)
                         ? w_op[1:0] : 2'b00;
    assign halted      = (r_state == S_HALT);
    assign illegal     = (r_state == S_DECODE) && w_is_illegal;

endmodule

// File: doc/exec_ctrl_fsm.md
Name: exec_ctrl_fsm

Overview:
Parametrised successor to the separate MOV/ALU control FSMs. It is a single multi-cycle execute controller that accepts one instruction word through a valid/ready handshake and decodes it. It sequences register-file read, ALU execute and register write-back, and owns the program counter. It adds jump, conditional jump on a latched zero flag, halt and illegal-opcode handling. It sits between instruction memory and the register file / ALU datapath.

Parameters:
OP_W, 4, opcode field width (values 0x0-0x7 defined; all others illegal)
RA_W, 5, register address field width (register count 2**RA_W)
PC_W, 5, program counter width
Derived: INSTR_W = OP_W + 3*RA_W (default 19). Fields, MSB to LSB: op, dst, srcA, srcB.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction word available
instr  in  INSTR_W  instruction word
instr_ready  out  1  controller can accept an instruction
pc  out  PC_W  program counter (address of the next fetch)
rd_en  out  1  register-file read strobe
rd_sel_a  out  RA_W  read port A select (srcA)
rd_sel_b  out  RA_W  read port B select (srcB)
wr_en  out  1  register-file write strobe, one-cycle pulse
wr_sel  out  RA_W  write select (dst)
mov_sel  out  1  1 = write-back source is read port A; 0 = ALU result
alu_fs  out  2  ALU function: 00 ADD, 01 SUB, 10 AND, 11 NOT
alu_zero  in  1  ALU result-is-zero, combinational from the ALU
halted  out  1  controller is in HALT
illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (asynchronous): state IDLE, pc=0, zero flag z=0, instruction register=0. All strobes and outputs are 0, except instr_ready=1.
- Opcodes: 0x0-0x3 ALU with alu_fs=op[1:0]; 0x4 MOV dst<-srcA; 0x5 JMP; 0x6 JZ; 0x7 HALT; >=0x8 illegal, executed as NOP.
- Jump target is srcB[PC_W-1:0], or srcB zero-extended if PC_W>RA_W.
- States: IDLE, DECODE, READ, EXEC, WRITE, HALT.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, capture instr and go to DECODE. Otherwise hold.
- DECODE: ALU or MOV -> READ.
  - JMP: pc<=target, go to IDLE.
  - JZ: pc<=z ? target : pc+1, go to IDLE.
  - HALT: go to HALT with pc unchanged.
  - Illegal: pulse illegal, pc<=pc+1, go to IDLE.
- READ: rd_en=1, rd_sel_a/b driven. ALU -> EXEC; MOV -> WRITE.
- EXEC: alu_fs driven; z<=alu_zero at the end of the cycle; go to WRITE.
- WRITE: wr_en=1 and wr_sel=dst. mov_sel=1 for MOV, 0 for ALU. alu_fs stays valid for ALU ops. pc<=pc+1, go to IDLE.
- rd_sel_a/b and wr_sel are 0 outside READ/EXEC/WRITE. alu_fs is 00 outside EXEC/WRITE. mov_sel is 0 outside WRITE.
- Latency, from the accept edge to instr_ready high again: ALU 4 cycles; MOV 3; JMP, JZ and illegal 1.
- The zero flag changes only on ALU ops; MOV and jumps preserve it.
- PC arithmetic is modulo 2**PC_W: pc+1 from all-ones wraps to 0.
- HALT: instr_ready=0, halted=1, no strobes. Leaves only via rst.
- instr_valid while not ready is ignored; the sender holds it.
- instr is sampled only on the accept edge, so later changes to instr have no effect.
- rst mid-instruction: immediate return to the reset state. No partial write occurs after rst asserts.

Test Plan:
1. Reset, then valid instr=19'b0000_11110_01111_01010 (ADD) -> accepted at edge 0. Edge 2: rd_en=1, sel_a=15, sel_b=10. Then alu_fs=00 in EXEC/WRITE. Edge 4: wr_en pulse with wr_sel=30 and mov_sel=0. pc=1 and instr_ready=1 on the 4th cycle.
2. MOV 0x4, dst=3, srcA=7 -> one rd_en cycle, then a wr_en pulse with wr_sel=3 and mov_sel=1. 3-cycle latency; alu_fs stays 00 and z is unchanged.
3. SUB with alu_zero=1, then JZ with srcB=5'd20 -> pc=20. Repeat with an AND while alu_zero=0, then JZ -> pc=old pc+1.
4. At pc=31, JMP to 31 followed by any ALU op -> pc wraps to 0. Opcode 0x9 -> illegal pulses exactly one cycle, there is no rd_en/wr_en, and pc increments.
5. HALT -> halted=1 and instr_ready=0. It stays there for 20 cycles with instr_valid=1. rst then returns to pc=0 and instr_ready=1.
6. Assert rst asynchronously (between edges) during EXEC of an ALU op -> outputs reset immediately. wr_en never asserts and z stays 0.
